line_pixel_gen: RTL and testbench

Bresenham iteration engine: the consumer of the precomputed line-parameter stage. It accepts one parameter set per line: x0, x1, y0, deltax, deltay, ystep and steep. It then walks x from x0 to x1 and emits one pixel coordinate per handshake, un-swapping coordinates for steep lines. It sits between the parameter precompute pipeline and the rasterizer/framebuffer write path.

---
 rtl/line_pixel_gen.sv | 133 +++++++++++++
 tb/tb_line_pixel_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_pixel_gen.sv
// Bresenham iterator: walks x from x0 to x1, one pixel per handshake; latency 1 cycle from accept.
// Backpressure: pixel held stable while pixel_ready low. Optional screen clipping under `LINE_CLIP_EN.
module line_pixel_gen #(
    parameter int WIDTH    = 13,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             param_valid,
    output logic             param_ready,
    input  logic [WIDTH-1:0] x0_in,
    input  logic [WIDTH-1:0] x1_in,
    input  logic [WIDTH-1:0] y0_in,
    input  logic [WIDTH-1:0] deltax_in,
    input  logic [WIDTH-1:0] deltay_in,
    input  logic [WIDTH-1:0] ystep_in,
    input  logic             steep_in,
    output logic             pixel_valid,
    input  logic             pixel_ready,
    output logic [WIDTH-1:0] pixel_x,
    output logic [WIDTH-1:0] pixel_y,
    output logic             line_done,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t                  state;
    logic signed [WIDTH-1:0] x, y, x_end, deltax, deltay, ystep;
    logic                    steep;
    logic signed [WIDTH:0]   err;
    logic                    draw_q;

    logic signed [WIDTH:0]   dx_ext, dy_ext, dx_in_ext, err_step;
    logic signed [WIDTH-1:0] cand_x, cand_y;
    logic                    advance;

    assign dx_ext    = {deltax[WIDTH-1], deltax};
    assign dy_ext    = {deltay[WIDTH-1], deltay};
    assign dx_in_ext = {deltax_in[WIDTH-1], deltax_in};
    assign err_step  = err - dy_ext;

    assign cand_x  = steep ? y : x;
    assign cand_y  = steep ? x : y;
    assign pixel_x = cand_x;
    assign pixel_y = cand_y;

`ifdef LINE_CLIP_EN
    localparam logic signed [WIDTH:0] SCR_W = (WIDTH+1)'(SCREEN_W);
    localparam logic signed [WIDTH:0] SCR_H = (WIDTH+1)'(SCREEN_H);

    logic signed [WIDTH:0] cx_ext, cy_ext;
    logic                  in_range;

    assign cx_ext   = {cand_x[WIDTH-1], cand_x};
    assign cy_ext   = {cand_y[WIDTH-1], cand_y};
    assign in_range = !cx_ext[WIDTH] && (cx_ext < SCR_W) &&
                      !cy_ext[WIDTH] && (cy_ext < SCR_H);

    // Clipped pixels are never shown; the iterator steps past them on its own.
    assign pixel_valid = draw_q & in_range;
    assign advance     = draw_q & (pixel_ready | ~in_range);
`else
    assign pixel_valid = draw_q;
    assign advance     = draw_q & pixel_ready;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            x_end       <= '0;
            deltax      <= '0;
            deltay      <= '0;
            ystep       <= '0;
            steep       <= 1'b0;
            err         <= '0;
            draw_q      <= 1'b0;
            param_ready <= 1'b1;
            busy        <= 1'b0;
            line_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    line_done <= 1'b0;
                    if (param_valid && param_ready) begin
                        x           <= x0_in;
                        y           <= y0_in;
                        x_end       <= x1_in;
                        deltax      <= deltax_in;
                        deltay      <= deltay_in;
                        ystep       <= ystep_in;
                        steep       <= steep_in;
                        err         <= dx_in_ext >>> 1;
                        draw_q      <= 1'b1;
                        param_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= DRAW;
                    end
                end
                DRAW: begin
                    if (advance) begin
                        if (x == x_end) begin
                            draw_q    <= 1'b0;
                            line_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            x <= x + ONE;
                            if (err_step[WIDTH]) begin
                                y   <= y + ystep;
                                err <= err_step + dx_ext;
                            end else begin
                                err <= err_step;
                            end
                        end
                    end
                end
                DONE: begin
                    line_done   <= 1'b0;
                    busy        <= 1'b0;
                    param_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_pixel_gen.sv
// Testbench for line_pixel_gen: directed lines plus randomized lines against a closed-form line model.
module tb_line_pixel_gen;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst;
    logic         param_valid, param_ready;
    logic [W-1:0] x0_in, x1_in, y0_in, deltax_in, deltay_in, ystep_in;
    logic         steep_in;
    logic         pixel_valid, pixel_ready;
    logic [W-1:0] pixel_x, pixel_y;
    logic         line_done, busy;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] got_q[$];
    int             got_cyc[$];
    int first_valid_cyc, done_cnt, done_cyc, stab_err, busy_err;
    bit accepted, timed_out;
    logic post_busy, post_ready, post_done;

    line_pixel_gen #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .param_valid(param_valid), .param_ready(param_ready),
        .x0_in(x0_in), .x1_in(x1_in), .y0_in(y0_in),
        .deltax_in(deltax_in), .deltay_in(deltay_in), .ystep_in(ystep_in),
        .steep_in(steep_in),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_done(line_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Closed form: after i x-steps, y has moved k = ceil((i*dy - floor(dx/2)) / dx) times (k >= 0).
    function automatic void build_expected(input int x0, input int y0, input int dx,
                                           input int dy, input int ys, input bit st);
        int h, k, n, px, py, sx, sy;
        exp_q.delete();
        h = dx / 2;
        for (int i = 0; i <= dx; i++) begin
            n  = i * dy - h;
            k  = (n <= 0) ? 0 : (n + dx - 1) / dx;
            px = x0 + i;
            py = y0 + ys * k;
            sx = st ? py : px;
            sy = st ? px : py;
`ifdef LINE_CLIP_EN
            if (sx < 0 || sx >= 640 || sy < 0 || sy >= 480) continue;
`endif
            exp_q.push_back({sx[W-1:0], sy[W-1:0]});
        end
    endfunction

    // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random
    task automatic run_line(input int x0, input int x1, input int y0, input int dx, input int dy,
                            input int ys, input bit st, input int mode, input bit pulse);
        logic [2*W-1:0] held;
        bit held_pending = 0;
        bit finished = 0;
        int budget = 4 * (dx + 1) + 20;
        got_q.delete();
        got_cyc.delete();
        first_valid_cyc = -1; done_cnt = 0; done_cyc = -1;
        stab_err = 0; busy_err = 0; timed_out = 0;
        @(negedge clk);
        accepted    = param_ready;
        x0_in       = x0[W-1:0];
        x1_in       = x1[W-1:0];
        y0_in       = y0[W-1:0];
        deltax_in   = dx[W-1:0];
        deltay_in   = dy[W-1:0];
        ystep_in    = ys[W-1:0];
        steep_in    = st;
        param_valid = 1'b1;
        @(posedge clk);
        #1;
        param_valid = 1'b0;
        x0_in = W'($urandom); x1_in = W'($urandom); y0_in = W'($urandom);
        deltax_in = W'($urandom); deltay_in = W'($urandom); steep_in = ~st;
        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clk);
            pixel_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            if (pulse) param_valid = (c == 2);
            if (held_pending && (!pixel_valid || {pixel_x, pixel_y} !== held)) stab_err++;
            if (pixel_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = c;
                if (pixel_ready) begin
                    got_q.push_back({pixel_x, pixel_y});
                    got_cyc.push_back(c);
                    held_pending = 0;
                end else begin
                    held = {pixel_x, pixel_y};
                    held_pending = 1;
                end
            end
            if (!busy) busy_err++;
            if (line_done) begin
                done_cnt++;
                done_cyc = c;
                finished = 1;
            end
        end
        param_valid = 1'b0;
        if (!finished) timed_out = 1;
        @(negedge clk);
        post_busy  = busy;
        post_ready = param_ready;
        post_done  = line_done;
        pixel_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; param_valid = 1'b0; pixel_ready = 1'b0;
        x0_in = '0; x1_in = '0; y0_in = '0; deltax_in = '0; deltay_in = '0; ystep_in = '0; steep_in = 0;
        repeat (2) @(negedge clk);
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pixel_valid); end
        checks++; if (pixel_x !== '0) begin errors++; $display("FAIL reset_x got %0d want 0", pixel_x); end
        checks++; if (pixel_y !== '0) begin errors++; $display("FAIL reset_y got %0d want 0", pixel_y); end
        checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", line_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (param_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", param_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_horizontal;
        int bad = 0;
        run_line(0, 4, 0, 4, 0, 1, 0, 0, 0);
        build_expected(0, 0, 4, 0, 1, 0);
        checks++; if (!accepted || timed_out) begin errors++; $display("FAIL horiz_handshake accepted %0d timeout %0d want 1 0", accepted, timed_out); end
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL horiz_count got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i] || got_cyc[i] != i) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL horiz_pixels got %0d wrong pixels/cycles want 0", bad); end
        checks++; if (first_valid_cyc != 0) begin errors++; $display("FAIL horiz_latency got %0d want 0", first_valid_cyc); end
        checks++; if (done_cyc != 5 || done_cnt != 1) begin errors++; $display("FAIL horiz_done got cyc %0d cnt %0d want 5 1", done_cyc, done_cnt); end
        checks++; if (post_busy !== 1'b0 || post_ready !== 1'b1 || post_done !== 1'b0) begin
            errors++; $display("FAIL horiz_idle got busy %b ready %b done %b want 0 1 0", post_busy, post_ready, post_done); end
        checks++; if (busy_err != 0) begin errors++; $display("FAIL horiz_busy got %0d low cycles want 0", busy_err); end
    endtask

    task automatic test_slope(input string name, input int x0, input int x1, input int y0,
                              input int dx, input int dy, input int ys, input bit st);
        int bad = 0;
        run_line(x0, x1, y0, dx, dy, ys, st, 0, 0);
        build_expected(x0, y0, dx, dy, ys, st);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count got %0d want %0d", name, got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s_pixel%0d got (%0d,%0d) want (%0d,%0d)", name, i,
                         got_q[i][2*W-1:W], got_q[i][W-1:0], exp_q[i][2*W-1:W], exp_q[i][W-1:0]);
            end
        checks++; if (bad != 0) errors++;
        checks++; if (done_cnt != 1 || timed_out) begin errors++; $display("FAIL %s_done got %0d want 1", name, done_cnt); end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        run_line(0, 4, 0, 4, 0, 1, 0, 1, 1);
        build_expected(0, 0, 4, 0, 1, 0);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_count got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_pixels got %0d wrong want 0", bad); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
        checks++; if (done_cnt != 1 || timed_out) begin errors++; $display("FAIL bp_done got %0d want 1", done_cnt); end
        checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_param got busy %b want 0", post_busy); end
    endtask

    task automatic test_single_pixel;
        run_line(7, 7, 9, 0, 0, 1, 0, 0, 0);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", got_q.size()); end
        checks++; if (got_q.size() > 0 && got_q[0] !== {13'd7, 13'd9}) begin
            errors++; $display("FAIL single_pixel got (%0d,%0d) want (7,9)", got_q[0][2*W-1:W], got_q[0][W-1:0]); end
        checks++; if (done_cyc != 1 || done_cnt != 1) begin errors++; $display("FAIL single_done got cyc %0d cnt %0d want 1 1", done_cyc, done_cnt); end
    endtask

    task automatic test_reset_midline;
        @(negedge clk);
        x0_in = 13'd0; x1_in = 13'd3; y0_in = 13'd3; deltax_in = 13'd3; deltay_in = 13'd3;
        ystep_in = '1; steep_in = 1'b0; param_valid = 1'b1; pixel_ready = 1'b1;
        @(posedge clk);
        #1 param_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (pixel_valid !== 1'b1 || pixel_x !== 13'd2 || pixel_y !== 13'd1) begin
            errors++; $display("FAIL midline_pre got v %b (%0d,%0d) want 1 (2,1)", pixel_valid, pixel_x, pixel_y); end
        rst = 1'b1;
        #1;
        checks++; if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midline_async got valid %b busy %b want 0 0", pixel_valid, busy); end
        checks++; if (pixel_x !== '0 || pixel_y !== '0) begin
            errors++; $display("FAIL midline_outputs got (%0d,%0d) want (0,0)", pixel_x, pixel_y); end
        @(negedge clk);
        rst = 1'b0; pixel_ready = 1'b0;
        @(negedge clk);
        checks++; if (param_ready !== 1'b1) begin errors++; $display("FAIL midline_ready got %b want 1", param_ready); end
        test_slope("after_reset", 0, 4, 0, 4, 0, 1, 0);
    endtask

    task automatic test_random;
        int dx, dy, ys, x0, y0, bad, lines_bad = 0;
        bit st;
        for (int n = 0; n < 12; n++) begin
            dx = $urandom_range(0, 30);
            dy = $urandom_range(0, dx);
            ys = $urandom_range(0, 1) ? 1 : -1;
            st = 1'($urandom_range(0, 1));
            x0 = $urandom_range(0, 400);
            y0 = $urandom_range(0, 400);
            run_line(x0, x0 + dx, y0, dx, dy, ys, st, 2, 0);
            build_expected(x0, y0, dx, dy, ys, st);
            bad = (got_q.size() != exp_q.size() || done_cnt != 1 || stab_err != 0) ? 1 : 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                if (got_q[i] !== exp_q[i]) bad = 1;
            if (bad != 0) begin
                lines_bad++;
                $display("FAIL random_line%0d got %0d pixels done %0d want %0d pixels done 1 (dx %0d dy %0d ys %0d st %0d)",
                         n, got_q.size(), done_cnt, exp_q.size(), dx, dy, ys, st);
            end
            checks++; if (bad != 0) errors++;
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_slope("neg_slope", 0, 3, 3, 3, 3, -1, 0);
        test_slope("steep", 0, 4, 0, 4, 2, 1, 1);
        test_backpressure();
        test_single_pixel();
        test_reset_midline();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
